// File: rtl/cdb_result_buffer.sv
// cdb_result_buffer
//
// Transmit-side common-data-bus interface for one functional unit. Completed
// results {tag, data} are queued in a small FIFO. The oldest entry is offered
// to the CDB arbitrator, and the offer is held until the arbitrator grants it.
// When several units complete in the same cycle, the results that lose
// arbitration wait in the buffer instead of being lost.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   en         global enable; 0 freezes all state
//   res_valid  unit presents a completed result this cycle
//   res_tag    result tag; bit TAG_W-1 is tag_valid
//   res_data   result value
//   res_ready  buffer can accept a result (not full)
//   cdb_req    head entry valid; requesting the CDB
//   cdb_tag    head tag, 0 when empty
//   cdb_data   head data, 0 when empty
//   cdb_grant  arbitrator takes the head entry this cycle
//   count      occupied entries
//   overflow   sticky: a valid result arrived while full
//
// Handshakes
//   Input side : a result is accepted at a rising edge when en, res_valid,
//                res_tag[TAG_W-1] and res_ready are all 1. res_ready depends
//                only on registered state, so the unit may look at it before
//                it decides to drive res_valid.
//   Output side: cdb_req/cdb_tag/cdb_data form the valid/data half. The
//                entry leaves at a rising edge when en, cdb_req and cdb_grant
//                are all 1. While the request is not granted, cdb_tag and
//                cdb_data stay unchanged.
module cdb_result_buffer #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       res_valid,
  input  logic [TAG_W-1:0]           res_tag,
  input  logic [DATA_W-1:0]          res_data,
  output logic                       res_ready,
  output logic                       cdb_req,
  output logic [TAG_W-1:0]           cdb_tag,
  output logic [DATA_W-1:0]          cdb_data,
  input  logic                       cdb_grant,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [TAG_W-1:0]  tag_mem  [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt_q;
  logic             overflow_q;

  logic offered;
  logic push;
  logic pop;

  // A result with tag_valid=0 is not a result at all. It can neither be
  // written nor flag an overflow.
  assign offered   = en & res_valid & res_tag[TAG_W-1];
  assign res_ready = (cnt_q < CNT_W'(DEPTH));
  assign cdb_req   = (cnt_q != '0);
  // A pop in the same cycle does not make room for a push. res_ready comes
  // from the occupancy at the start of the cycle.
  assign push      = offered & res_ready;
  assign pop       = en & cdb_grant & cdb_req;

  assign count     = cnt_q;
  assign overflow  = overflow_q;

  // The head is read straight from storage. There is no bypass, so a new
  // result can only become the head after the edge that writes it.
  always_comb begin
    cdb_tag  = '0;
    cdb_data = '0;
    if (cdb_req) begin
      cdb_tag  = tag_mem[rd_ptr];
      cdb_data = data_mem[rd_ptr];
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally at DEPTH-1 -> 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (offered && !res_ready) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Storage needs no reset. Empty slots are never visible because the
  // outputs are forced to zero whenever count is 0.
  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem[wr_ptr]  <= res_tag;
      data_mem[wr_ptr] <= res_data;
    end
  end

endmodule

// File: tb/tb_cdb_result_buffer.sv
module tb_cdb_result_buffer;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 8;
  localparam int CNT_W  = $clog2(DEPTH+1);
  localparam int W      = TAG_W + DATA_W;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              reset;
  logic              en;
  logic              res_valid;
  logic [TAG_W-1:0]  res_tag;
  logic [DATA_W-1:0] res_data;
  logic              res_ready;
  logic              cdb_req;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              cdb_grant;
  logic [CNT_W-1:0]  count;
  logic              overflow;

  always #5 clk = ~clk;

  cdb_result_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .res_valid (res_valid),
    .res_tag   (res_tag),
    .res_data  (res_data),
    .res_ready (res_ready),
    .cdb_req   (cdb_req),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .cdb_grant (cdb_grant),
    .count     (count),
    .overflow  (overflow)
  );

  // ---------------- scoreboard / reference model ----------------
  // The buffer is modelled as a plain queue of accepted {tag, data} entries
  // plus a sticky overflow flag.
  logic [W-1:0]     exp_q[$];
  logic [TAG_W-1:0] pop_log[$];
  logic             exp_ovf;
  int               n_checks = 0;
  int               n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string ctx);
    int n;
    n = exp_q.size();
    check({ctx, ".count"},     64'(count),     64'(n));
    check({ctx, ".cdb_req"},   64'(cdb_req),   64'(n != 0));
    check({ctx, ".cdb_tag"},   64'(cdb_tag),   (n != 0) ? 64'(exp_q[0][W-1:DATA_W]) : 64'd0);
    check({ctx, ".cdb_data"},  64'(cdb_data),  (n != 0) ? 64'(exp_q[0][DATA_W-1:0]) : 64'd0);
    check({ctx, ".res_ready"}, 64'(res_ready), 64'(n < DEPTH));
    check({ctx, ".overflow"},  64'(overflow),  64'(exp_ovf));
  endtask

  // ---------------- driver tasks ----------------
  // Called in the low phase of the clock. Drives one cycle of inputs, lets
  // the model take the edge, and checks the outputs at the next falling edge.
  task automatic cycle(input logic v, input logic [TAG_W-1:0] t,
                       input logic [DATA_W-1:0] d, input logic g,
                       input logic e, input string ctx);
    bit full, m_push, m_pop, offered;
    en        = e;
    res_valid = v;
    res_tag   = t;
    res_data  = d;
    cdb_grant = g;
    full    = (exp_q.size() == DEPTH);
    offered = e && v && t[TAG_W-1];
    m_push  = offered && !full;
    m_pop   = e && g && (exp_q.size() != 0);
    @(posedge clk);
    if (m_pop) begin
      pop_log.push_back(exp_q[0][W-1:DATA_W]);
      void'(exp_q.pop_front());
    end
    if (m_push) exp_q.push_back({t, d});
    if (offered && full) exp_ovf = 1'b1;
    @(negedge clk);
    check_outputs(ctx);
  endtask

  task automatic idle(input string ctx);
    cycle(1'b0, '0, '0, 1'b0, 1'b1, ctx);
  endtask

  // Asserts reset halfway through the low phase, checks that the clear took
  // effect without any clock edge, then holds reset across one edge.
  task automatic apply_reset(input string ctx);
    #2;
    reset = 1'b0;
    exp_q.delete();
    exp_ovf = 1'b0;
    #1;
    check_outputs({ctx, ".async"});
    @(negedge clk);
    check_outputs({ctx, ".held"});
    reset = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [TAG_W-1:0] exp_tags [10];
    reset = 1'b0; en = 1'b0; res_valid = 1'b0; res_tag = '0; res_data = '0; cdb_grant = 1'b0;
    exp_ovf = 1'b0;
    @(negedge clk);
    check_outputs("por");
    reset = 1'b1;

    // 1. reset mid-stream with three entries queued
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 8'hB0 + 8'(i), 32'h100 + 32'(i), 1'b0, 1'b1, "t1.fill");
    apply_reset("t1.reset");

    // 2. single entry held across ungranted cycles, then granted
    cycle(1'b1, 8'hA1, 32'h0000_1234, 1'b0, 1'b1, "t2.push");
    for (int i = 0; i < 3; i++) begin
      idle("t2.hold");
      check("t2.hold_tag", 64'(cdb_tag), 64'hA1);
      check("t2.hold_data", 64'(cdb_data), 64'h1234);
    end
    cycle(1'b0, '0, '0, 1'b1, 1'b1, "t2.grant");
    check("t2.req_after_grant", 64'(cdb_req), 64'd0);

    // 3. fill, overflow, full with simultaneous grant, drain in order
    pop_log.delete();
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 8'hA1 + 8'(i), 32'hA00 + 32'(i), 1'b0, 1'b1, "t3.fill");
    check("t3.full_ready", 64'(res_ready), 64'd0);
    cycle(1'b1, 8'hA5, 32'hA05, 1'b0, 1'b1, "t3.over");
    check("t3.ovf", 64'(overflow), 64'd1);
    // full + grant: the entry leaves, but the offered result is dropped
    cycle(1'b1, 8'hA6, 32'hA06, 1'b1, 1'b1, "t3.full_pop");
    for (int i = 0; i < 4; i++)
      cycle(1'b0, '0, '0, 1'b1, 1'b1, "t3.drain");
    check("t3.pop_n", 64'(pop_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < pop_log.size(); i++)
      check("t3.order", 64'(pop_log[i]), 64'(8'hA1 + 8'(i)));
    check("t3.ovf_sticky", 64'(overflow), 64'd1);

    // 4. push together with a grant at count=2
    apply_reset("t4.reset");
    cycle(1'b1, 8'hA1, 32'h1, 1'b0, 1'b1, "t4.fill");
    cycle(1'b1, 8'hA2, 32'h2, 1'b0, 1'b1, "t4.fill");
    cycle(1'b1, 8'hA3, 32'h3, 1'b1, 1'b1, "t4.both");
    check("t4.count", 64'(count), 64'd2);
    check("t4.head", 64'(cdb_tag), 64'hA2);
    cycle(1'b0, '0, '0, 1'b1, 1'b1, "t4.pop");
    check("t4.head2", 64'(cdb_tag), 64'hA3);
    cycle(1'b0, '0, '0, 1'b1, 1'b1, "t4.pop");

    // 5. stream of ten results with a grant every other cycle; pointers wrap
    pop_log.delete();
    for (int i = 0; i < 10; i++) exp_tags[i] = 8'hC0 + 8'(i);
    for (int k = 0; k < 20; k++)
      cycle(k % 2 == 0, 8'hC0 + 8'(k / 2), $urandom, k % 2 == 1, 1'b1, "t5.stream");
    check("t5.pop_n", 64'(pop_log.size()), 64'd10);
    for (int i = 0; i < 10 && i < pop_log.size(); i++)
      check("t5.order", 64'(pop_log[i]), 64'(exp_tags[i]));
    check("t5.ovf", 64'(overflow), 64'd0);

    // 6. tag_valid=0 ignored; en=0 freezes everything
    cycle(1'b1, 8'h21, 32'hDEAD, 1'b0, 1'b1, "t6.invalid_tag");
    check("t6.count0", 64'(count), 64'd0);
    cycle(1'b1, 8'hD1, 32'hD1D1, 1'b0, 1'b1, "t6.push");
    cycle(1'b1, 8'hD2, 32'hD2D2, 1'b1, 1'b0, "t6.frozen");
    check("t6.head", 64'(cdb_tag), 64'hD1);
    check("t6.count1", 64'(count), 64'd1);
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 8'hD3 + 8'(i), 32'h0, 1'b0, 1'b1, "t6.fill");
    cycle(1'b1, 8'hDF, 32'h0, 1'b0, 1'b0, "t6.frozen_full");
    check("t6.no_ovf", 64'(overflow), 64'd0);

    // 7. randomized traffic against the queue model
    apply_reset("t7.reset");
    for (int k = 0; k < 400; k++) begin
      logic [TAG_W-1:0] t;
      t = 8'($urandom);
      t[TAG_W-1] = ($urandom_range(0, 9) != 0);
      cycle($urandom_range(0, 1) == 1, t, $urandom, $urandom_range(0, 2) == 0,
            $urandom_range(0, 9) != 0, "t7.rand");
      if (k == 200) apply_reset("t7.midreset");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
